// File: rtl/freq_counter_if.sv
// Measurement bus of the gated frequency counter: input signal plus latched BCD result.
// DIGITS must match the DIGITS parameter of the freq_counter attached as master.
interface freq_counter_if #(
    parameter int DIGITS = 4
);
    logic                  sig_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;
    logic                  valid;
    logic                  gate;

    modport master (
        input  sig_in,
        output bcd_out,
        output ovf,
        output valid,
        output gate
    );

    modport slave (
        output sig_in,
        input  bcd_out,
        input  ovf,
        input  valid,
        input  gate
    );
endinterface

// File: rtl/freq_counter.sv
// Gated frequency counter: counts sig_in rising edges per PRESCALE*GATE_TICKS-cycle window into BCD.
// Result registered one cycle after window end with a one-cycle valid pulse; no backpressure.
module freq_counter #(
    parameter int PRESCALE   = 50000,
    parameter int GATE_TICKS = 1000,
    parameter int DIGITS     = 4
) (
    input  logic           clk,
    input  logic           rst,
    freq_counter_if.master bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int GW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_TICKS - 1);

    logic                   s1, s2, s3;
    logic                   rise;
    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic [GW-1:0]          gate_cnt;
    logic                   win_end;
    logic [DIGITS-1:0][3:0] acc, acc_inc, acc_nxt;
    logic                   sat, sat_nxt;
    logic                   all_nine, carry;
    logic [4*DIGITS-1:0]    bcd_q;
    logic                   ovf_q, valid_q, gate_q;

    assign rise    = s2 & ~s3;
    assign tick    = (pre_cnt == PRE_LAST);
    assign win_end = tick & (gate_cnt == GATE_LAST);

    // Digits at 9 or above wrap to 0, so no A-F code can ever propagate.
    always_comb begin
        acc_inc  = acc;
        carry    = 1'b1;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_nine = all_nine & (acc[i] == 4'd9);
            if (carry) begin
                if (acc[i] >= 4'd9) begin
                    acc_inc[i] = 4'd0;
                end else begin
                    acc_inc[i] = acc[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end

        acc_nxt = acc;
        sat_nxt = sat;
        if (rise) begin
            if (all_nine) begin
                sat_nxt = 1'b1;
            end else begin
                acc_nxt = acc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            pre_cnt  <= '0;
            gate_cnt <= '0;
            acc      <= '0;
            sat      <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;

            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
            if (tick) begin
                gate_cnt <= (gate_cnt == GATE_LAST) ? '0 : gate_cnt + GW'(1);
            end

            valid_q <= win_end;
            // A rise in the win_end cycle is folded into the closing result via acc_nxt.
            if (win_end) begin
                bcd_q  <= acc_nxt;
                ovf_q  <= sat_nxt;
                acc    <= '0;
                sat    <= 1'b0;
                gate_q <= ~gate_q;
            end else begin
                acc <= acc_nxt;
                sat <= sat_nxt;
            end
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
    assign bus.valid   = valid_q;
    assign bus.gate    = gate_q;
endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: three instances (4, 2 and 1 digits) share one stimulus; a
// behavioural edge-count model pushes expected window results that the scenario tasks pop.
module tb_freq_counter;
    localparam int P = 4;
    localparam int G = 5;
    localparam int W = P * G;

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;

    int checks = 0;
    int errors = 0;

    int   gen_period = 0;
    int   gen_ph     = 0;
    logic gen_level  = 1'b0;

    freq_counter_if #(.DIGITS(4)) b4 ();
    freq_counter_if #(.DIGITS(2)) b2 ();
    freq_counter_if #(.DIGITS(1)) b1 ();

    assign b4.sig_in = sig;
    assign b2.sig_in = sig;
    assign b1.sig_in = sig;

    freq_counter #(.PRESCALE(P), .GATE_TICKS(G), .DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    freq_counter #(.PRESCALE(P), .GATE_TICKS(G), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    freq_counter #(.PRESCALE(P), .GATE_TICKS(G), .DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    // Stimulus source: square wave of gen_period cycles, or a static gen_level when period is 0.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gen_period > 0) begin
                gen_ph = (gen_ph + 1) % gen_period;
                sig = (gen_ph < gen_period / 2);
            end else begin
                sig = gen_level;
            end
        end
    end

    // Reference model: an input edge sampled at clk edge m is counted at edge m+2.
    exp_t q4[$];
    exp_t q2[$];
    exp_t q1[$];
    int   mdl_n;
    logic mdl_prev, mdl_d1, mdl_d2;
    int   mdl_cnt[3];
    logic mdl_sat[3];

    function automatic int maxv(input int inst);
        case (inst)
            0:       return 9999;
            1:       return 99;
            default: return 9;
        endcase
    endfunction

    function automatic logic [31:0] bin2bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic r;
        exp_t e;
        if (rst) begin
            mdl_n = 0;
            mdl_prev = 1'b0;
            mdl_d1 = 1'b0;
            mdl_d2 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                mdl_cnt[i] = 0;
                mdl_sat[i] = 1'b0;
            end
            q4.delete();
            q2.delete();
            q1.delete();
        end else begin
            r        = mdl_d2;
            mdl_d2   = mdl_d1;
            mdl_d1   = sig & ~mdl_prev;
            mdl_prev = sig;
            mdl_n++;
            for (int i = 0; i < 3; i++) begin
                if (r) begin
                    if (mdl_cnt[i] == maxv(i)) mdl_sat[i] = 1'b1;
                    else mdl_cnt[i]++;
                end
            end
            if (mdl_n % W == 0) begin
                for (int i = 0; i < 3; i++) begin
                    e.bcd = bin2bcd(mdl_cnt[i]);
                    e.ovf = mdl_sat[i];
                    case (i)
                        0:       q4.push_back(e);
                        1:       q2.push_back(e);
                        default: q1.push_back(e);
                    endcase
                    mdl_cnt[i] = 0;
                    mdl_sat[i] = 1'b0;
                end
            end
        end
    end

    task automatic pop_exp(input int inst, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (inst)
            0: if (q4.size() > 0) begin e = q4.pop_front(); ok = 1'b1; end
            1: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            default: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic sample_out(input int inst, output logic [31:0] bcd, output logic o,
                              output logic v, output logic g);
        case (inst)
            0: begin bcd = 32'(b4.bcd_out); o = b4.ovf; v = b4.valid; g = b4.gate; end
            1: begin bcd = 32'(b2.bcd_out); o = b2.ovf; v = b2.valid; g = b2.gate; end
            default: begin bcd = 32'(b1.bcd_out); o = b1.ovf; v = b1.valid; g = b1.gate; end
        endcase
    endtask

    // Returns the number of falling edges until valid, or -1 if the budget expires.
    task automatic wait_valid(input int inst, input int limit, output int cyc,
                              output logic [31:0] bcd, output logic o, output logic g);
        logic v;
        cyc = -1;
        bcd = '0;
        o   = 1'b0;
        g   = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            sample_out(inst, bcd, o, v, g);
            if (v === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] bcd;
        logic        o, v, g;
        int          cyc;
        gen_period = 0;
        gen_level  = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sample_out(i, bcd, o, v, g);
            checks++;
            if (bcd !== 32'h0 || o !== 1'b0 || v !== 1'b0 || g !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got bcd=%h ovf=%b valid=%b gate=%b, want all 0",
                         i, bcd, o, v, g);
            end
        end
        wait_valid(0, 25, cyc, bcd, o, g);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL reset_first_window: valid after %0d cycles, want %0d", cyc, W);
        end
    endtask

    task automatic test_square();
        logic [31:0] bcd;
        logic        o, g, gexp;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 4;
        gen_ph     = 0;
        do_reset();
        gexp = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            wait_valid(0, 25, cyc, bcd, o, g);
            checks++;
            if (cyc !== W) begin
                errors++;
                $display("FAIL square_interval w%0d: got %0d cycles, want %0d", w, cyc, W);
            end
            if (cyc > 0) begin
                pop_exp(0, e, ok);
                checks++;
                if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                    errors++;
                    $display("FAIL square_model w%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b (exp present=%0d)",
                             w, bcd, o, e.bcd, e.ovf, ok);
                end
                gexp = ~gexp;
                checks++;
                if (g !== gexp) begin
                    errors++;
                    $display("FAIL square_gate w%0d: got %b, want %b", w, g, gexp);
                end
                if (w >= 2) begin
                    checks++;
                    if (bcd !== 32'h0005 || o !== 1'b0) begin
                        errors++;
                        $display("FAIL square_steady w%0d: got bcd=%h ovf=%b, want 0005/0", w, bcd, o);
                    end
                end
            end
        end
    endtask

    task automatic test_static_levels();
        logic [31:0] bcd;
        logic        o, g;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 0;
        gen_level  = 1'b0;
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            wait_valid(0, 25, cyc, bcd, o, g);
            checks++;
            if (cyc !== W) begin
                errors++;
                $display("FAIL static_interval w%0d: got %0d cycles, want %0d", w, cyc, W);
            end
            if (cyc > 0) begin
                pop_exp(0, e, ok);
                checks++;
                if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                    errors++;
                    $display("FAIL static_model w%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                             w, bcd, o, e.bcd, e.ovf);
                end
                if (w != 3) begin
                    checks++;
                    if (bcd !== 32'h0 || o !== 1'b0) begin
                        errors++;
                        $display("FAIL static_zero w%0d: got bcd=%h ovf=%b, want 0000/0", w, bcd, o);
                    end
                end
            end
            if (w == 2) gen_level = 1'b1;
        end
    endtask

    task automatic test_bcd_carry();
        logic [31:0] bcd;
        logic        o, g;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 2;
        gen_ph     = 0;
        do_reset();
        for (int w = 1; w <= 3; w++) begin
            wait_valid(1, 25, cyc, bcd, o, g);
            checks++;
            if (cyc < 0) begin
                errors++;
                $display("FAIL carry_timeout w%0d: no valid within 25 cycles", w);
            end else begin
                pop_exp(1, e, ok);
                if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                    errors++;
                    $display("FAIL carry_model w%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                             w, bcd, o, e.bcd, e.ovf);
                end
                if (w >= 2) begin
                    checks++;
                    if (bcd !== 32'h10 || o !== 1'b0) begin
                        errors++;
                        $display("FAIL carry_steady w%0d: got bcd=%h ovf=%b, want 10/0", w, bcd, o);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] bcd;
        logic        o, g;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 2;
        gen_ph     = 0;
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            wait_valid(2, 25, cyc, bcd, o, g);
            checks++;
            if (cyc < 0) begin
                errors++;
                $display("FAIL sat_timeout w%0d: no valid within 25 cycles", w);
            end else begin
                pop_exp(2, e, ok);
                if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                    errors++;
                    $display("FAIL sat_model w%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                             w, bcd, o, e.bcd, e.ovf);
                end
                if (w == 2) begin
                    checks++;
                    if (bcd !== 32'h9 || o !== 1'b1) begin
                        errors++;
                        $display("FAIL sat_full w%0d: got bcd=%h ovf=%b, want 9/1", w, bcd, o);
                    end
                end
                if (w == 4) begin
                    checks++;
                    if (bcd !== 32'h5 || o !== 1'b0) begin
                        errors++;
                        $display("FAIL sat_recover w%0d: got bcd=%h ovf=%b, want 5/0", w, bcd, o);
                    end
                end
            end
            if (w == 2) gen_period = 4;
        end
    endtask

    task automatic test_boundary_edge();
        logic [31:0] bcd;
        logic        o, g;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 0;
        gen_level  = 1'b0;
        do_reset();
        // Level applied after edge 17, sampled at edge 18, so the rise coincides with win_end.
        repeat (16) @(negedge clk);
        gen_level = 1'b1;
        for (int w = 1; w <= 2; w++) begin
            wait_valid(0, 25, cyc, bcd, o, g);
            checks++;
            if (cyc !== ((w == 1) ? 4 : W)) begin
                errors++;
                $display("FAIL boundary_interval w%0d: got %0d cycles, want %0d", w, cyc, (w == 1) ? 4 : W);
            end
            if (cyc > 0) begin
                pop_exp(0, e, ok);
                checks++;
                if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                    errors++;
                    $display("FAIL boundary_model w%0d: got bcd=%h ovf=%b, want bcd=%h ovf=%b",
                             w, bcd, o, e.bcd, e.ovf);
                end
                checks++;
                if (bcd !== ((w == 1) ? 32'h0001 : 32'h0000) || o !== 1'b0) begin
                    errors++;
                    $display("FAIL boundary_count w%0d: got bcd=%h ovf=%b, want %0d/0", w, bcd, o, (w == 1) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] bcd;
        logic        o, v, g;
        int          cyc;
        exp_t        e;
        bit          ok;
        gen_period = 4;
        gen_ph     = 0;
        do_reset();
        wait_valid(0, 25, cyc, bcd, o, g);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL midrst_pre_window: got %0d cycles, want %0d", cyc, W);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sample_out(0, bcd, o, v, g);
        checks++;
        if (bcd !== 32'h0 || o !== 1'b0 || v !== 1'b0 || g !== 1'b0) begin
            errors++;
            $display("FAIL midrst_cleared: got bcd=%h ovf=%b valid=%b gate=%b, want all 0", bcd, o, v, g);
        end
        wait_valid(0, 25, cyc, bcd, o, g);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL midrst_interval: got %0d cycles after reset, want %0d", cyc, W);
        end
        if (cyc > 0) begin
            pop_exp(0, e, ok);
            checks++;
            if (!ok || bcd !== e.bcd || o !== e.ovf) begin
                errors++;
                $display("FAIL midrst_model: got bcd=%h ovf=%b, want bcd=%h ovf=%b", bcd, o, e.bcd, e.ovf);
            end
            checks++;
            if (bcd < 32'h4 || bcd > 32'h6 || o !== 1'b0) begin
                errors++;
                $display("FAIL midrst_range: got bcd=%h ovf=%b, want 0004..0006/0", bcd, o);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_square();
        test_static_levels();
        test_bcd_carry();
        test_saturation();
        test_boundary_edge();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
